keypad_scanner: RTL and testbench

//  4x4 matrix-keypad scanner/encoder; the producer side of the digit interface (key_in/key_valid/enter).

---
 rtl/keypad_pkg.sv | 36 +++
 rtl/keypad_sync.sv | 21 ++
 rtl/keypad_scanner.sv | 154 +++++++++++++++
 tb/tb_keypad_scanner.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM states, keymap and '#' position.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } kp_state_e;

  localparam logic [3:0] KEY_STAR  = 4'hE;
  localparam logic [1:0] ENTER_ROW = 2'd3;
  localparam logic [1:0] ENTER_COL = 2'd2;

  // Indexed by {row, col}; the '#' slot is never emitted as a code.
  localparam logic [3:0] KEYMAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    KEY_STAR, 4'h0, 4'hF, 4'hD
  };

  function automatic logic [1:0] lowest_low(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] col);
    return ~(4'b0001 << col);
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous active-low keypad rows; idles high.
module keypad_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] raw,
  output logic [3:0] synced
);

  logic [3:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta   <= 4'hF;
      synced <= 4'hF;
    end else begin
      meta   <= raw;
      synced <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column scan, press/release debounce, key_valid/enter pulses.
// Optional auto-repeat of held keys with KEYPAD_AUTOREPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 16,
  parameter int unsigned DEBOUNCE_CNT = 1000,
  parameter int unsigned REPEAT_TICKS = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_in,
  output logic       key_valid,
  output logic       enter,
  output logic       key_down
);

  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam int unsigned CW = $clog2(DEBOUNCE_CNT);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CNT - 1);

  if (SCAN_DIV < 4 || DEBOUNCE_CNT < 2 || REPEAT_TICKS < 1) begin : g_bad_params
    $error("keypad_scanner: parameter out of range");
  end

  logic [3:0]    rs;
  kp_state_e     state;
  logic [1:0]    col;
  logic [1:0]    row;
  logic [3:0]    pat;
  logic [DW-1:0] dwell;
  logic [CW-1:0] cnt;
  logic [1:0]    col_next;
  logic          at_enter;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);
  logic [RW-1:0] rep_cnt;
`endif

  keypad_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .raw    (row_in),
    .synced (rs)
  );

  assign col_next = col + 2'd1;
  assign at_enter = (row == ENTER_ROW) && (col == ENTER_COL);

  // Scan/debounce FSM; the column stays parked from a latched press until release completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SCAN;
      col       <= 2'd0;
      col_out   <= 4'b1110;
      row       <= 2'd0;
      pat       <= 4'hF;
      dwell     <= '0;
      cnt       <= '0;
      key_in    <= 4'h0;
      key_valid <= 1'b0;
      enter     <= 1'b0;
      key_down  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt   <= '0;
`endif
    end else begin
      key_valid <= 1'b0;
      enter     <= 1'b0;
      unique case (state)
        SCAN: begin
          if (dwell == DWELL_LAST) begin
            dwell <= '0;
            if (rs != 4'hF) begin
              state <= DB_PRESS;
              pat   <= rs;
              row   <= lowest_low(rs);
              cnt   <= '0;
            end else begin
              col     <= col_next;
              col_out <= col_drive(col_next);
            end
          end else begin
            dwell <= dwell + DW'(1);
          end
        end
        DB_PRESS: begin
          if (rs == pat) begin
            if (cnt == CNT_LAST) begin
              if (at_enter) begin
                enter <= 1'b1;
              end else begin
                key_valid <= 1'b1;
                key_in    <= KEYMAP[{row, col}];
              end
              key_down <= 1'b1;
              state    <= HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_cnt  <= '0;
`endif
            end else begin
              cnt <= cnt + CW'(1);
            end
          end else begin
            state   <= SCAN;
            col     <= col_next;
            col_out <= col_drive(col_next);
            dwell   <= '0;
          end
        end
        HELD: begin
          if (rs == 4'hF) begin
            cnt   <= '0;
            state <= DB_RELEASE;
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          else if (rep_cnt == REP_LAST) begin
            rep_cnt <= '0;
            if (!at_enter) key_valid <= 1'b1;
          end else begin
            rep_cnt <= rep_cnt + RW'(1);
          end
`endif
        end
        DB_RELEASE: begin
          if (rs == 4'hF) begin
            if (cnt == CNT_LAST) begin
              key_down <= 1'b0;
              state    <= SCAN;
              col      <= col_next;
              col_out  <= col_drive(col_next);
              dwell    <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end else begin
            state <= HELD;
            cnt   <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt <= '0;
`endif
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, event-level reference model, per-cycle compare.
module tb_keypad_scanner;

  localparam int unsigned SCAN_DIV     = 4;
  localparam int unsigned DEBOUNCE_CNT = 8;
  localparam int unsigned REPEAT_TICKS = 40;
  localparam int P_SCAN = 0, P_PRESS = 1, P_HELD = 2, P_REL = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row_in, col_out, key_in;
  logic        key_valid, enter, key_down;
  logic [15:0] pressed = '0;

  int    checks = 0;
  int    failures = 0;
  string keys = "123A456B789C*0#D";
  string dev = "";
  string mev = "";
  logic [3:0] exp_cols [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  keypad_scanner #(
    .SCAN_DIV    (SCAN_DIV),
    .DEBOUNCE_CNT(DEBOUNCE_CNT),
    .REPEAT_TICKS(REPEAT_TICKS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_in   (key_in),
    .key_valid(key_valid),
    .enter    (enter),
    .key_down (key_down)
  );

  always #5 clk = ~clk;

  // A pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int k = 0; k < 16; k++)
      if (pressed[k] && !col_out[k % 4]) row_in[k / 4] = 1'b0;
  end

  function automatic logic [3:0] code_of(input byte ch);
    if (ch >= "0" && ch <= "9") return 4'(int'(ch) - 48);
    if (ch >= "A" && ch <= "D") return 4'(int'(ch) - 65 + 10);
    return 4'hE;
  endfunction

  function automatic byte char_of(input logic [3:0] code);
    if (code <= 4'd9) return byte'(48 + int'(code));
    if (code <= 4'hD) return byte'(65 + int'(code) - 10);
    if (code == 4'hE) return byte'(42);
    return byte'(63);
  endfunction

  function automatic int key_idx(input byte ch);
    for (int i = 0; i < 16; i++) if (keys[i] == ch) return i;
    return 0;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp_v, $time);
    end
  endfunction

  function automatic void chk_str(input string name, input string act, input string exp_s);
    checks++;
    if (act != exp_s) begin
      failures++;
      $display("FAIL %s actual=\"%s\" required=\"%s\"", name, act, exp_s);
    end
  endfunction

  // ---------------- reference model ----------------
  int         m_phase, m_col, m_dwell, m_run, m_age, m_row;
  logic [3:0] m_pat, m_s1, m_s2, m_rs, m_key;
  logic       m_kv, m_en, m_kd, m_fire;
  byte        m_ch;

  function automatic logic [3:0] rows_for(input int c);
    logic [3:0] r;
    r = 4'hF;
    for (int k = 0; k < 16; k++) if (pressed[k] && (k % 4) == c) r[k / 4] = 1'b0;
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = P_SCAN; m_col = 0; m_dwell = 0; m_run = 0; m_age = 0; m_row = 0;
      m_pat = 4'hF; m_s1 = 4'hF; m_s2 = 4'hF; m_key = 4'h0;
      m_kv = 1'b0; m_en = 1'b0; m_kd = 1'b0;
    end else begin
      m_rs = m_s2;
      m_s2 = m_s1;
      m_s1 = rows_for(m_col);
      m_kv = 1'b0; m_en = 1'b0; m_fire = 1'b0;
      case (m_phase)
        P_SCAN: begin
          m_dwell++;
          if (m_dwell == SCAN_DIV) begin
            m_dwell = 0;
            if (m_rs != 4'hF) begin
              m_phase = P_PRESS;
              m_pat = m_rs;
              m_run = 1;
              for (int i = 3; i >= 0; i--) if (!m_rs[i]) m_row = i;
            end else m_col = (m_col + 1) % 4;
          end
        end
        P_PRESS: begin
          if (m_rs == m_pat) begin
            m_run++;
            if (m_run == DEBOUNCE_CNT + 1) begin
              m_fire = 1'b1; m_kd = 1'b1; m_phase = P_HELD; m_age = 0;
            end
          end else begin
            m_phase = P_SCAN; m_col = (m_col + 1) % 4; m_dwell = 0;
          end
        end
        P_HELD: begin
          if (m_rs == 4'hF) begin
            m_phase = P_REL; m_run = 1;
          end else begin
            m_age++;
`ifdef KEYPAD_AUTOREPEAT_EN
            if (m_age % REPEAT_TICKS == 0 && keys[m_row * 4 + m_col] != "#") m_fire = 1'b1;
`endif
          end
        end
        default: begin
          if (m_rs == 4'hF) begin
            m_run++;
            if (m_run == DEBOUNCE_CNT + 1) begin
              m_kd = 1'b0; m_phase = P_SCAN; m_col = (m_col + 1) % 4; m_dwell = 0;
            end
          end else begin
            m_phase = P_HELD; m_age = 0;
          end
        end
      endcase
      if (m_fire) begin
        m_ch = keys[m_row * 4 + m_col];
        mev = $sformatf("%s%c", mev, m_ch);
        if (m_ch == "#") m_en = 1'b1;
        else begin
          m_kv = 1'b1;
          m_key = code_of(m_ch);
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model, plus DUT event log.
  always @(negedge clk) begin
    logic [3:0] ecol;
    if (!reset) begin
      ecol = ~(4'b0001 << m_col);
      chk("col_out", 32'(col_out), 32'(ecol));
      chk("key_in", 32'(key_in), 32'(m_key));
      chk("key_valid", 32'(key_valid), 32'(m_kv));
      chk("enter", 32'(enter), 32'(m_en));
      chk("key_down", 32'(key_down), 32'(m_kd));
      if (key_valid === 1'b1) dev = $sformatf("%s%c", dev, char_of(key_in));
      if (enter === 1'b1) dev = $sformatf("%s#", dev);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic clear_events();
    dev = "";
    mev = "";
  endtask

  task automatic check_events(input string name, input string exp_s);
    chk_str({name, "_dut"}, dev, exp_s);
    chk_str({name, "_model"}, mev, exp_s);
  endtask

  task automatic wait_kd(input logic lvl, input string name);
    int n;
    n = 0;
    while (key_down !== lvl && n < 200) begin
      step(1);
      n++;
    end
    chk(name, 32'(n < 200), 32'd1);
  endtask

  task automatic tap(input byte ch, input int hold, input int gap);
    pressed[key_idx(ch)] = 1'b1;
    step(hold);
    pressed = '0;
    step(gap);
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_col"}, 32'(col_out), 32'h0000_000E);
    chk({name, "_key_in"}, 32'(key_in), 32'h0);
    chk({name, "_kv"}, 32'(key_valid), 32'h0);
    chk({name, "_enter"}, 32'(enter), 32'h0);
    chk({name, "_kd"}, 32'(key_down), 32'h0);
  endtask

  initial begin
    logic [15:0] saved;
    string seq;
    seq = "4279#";

    step(2);
    chk_reset_vals("por");
    reset = 1'b0;

    // idle scan rotation
    for (int j = 0; j < 16; j++) begin
      step(1);
      chk("scan_col", 32'(col_out), 32'(exp_cols[((j + 1) / 4) % 4]));
    end
    check_events("idle", "");

    // '5' press and release; scan resumes on column 2
    clear_events();
    pressed[key_idx("5")] = 1'b1;
    step(45);
    pressed = '0;
    wait_kd(1'b0, "rel5_timeout");
    chk("rel5_next_col", 32'(col_out), 32'h0000_000B);
    step(30);
    check_events("key5", "5");

    // '#' gives enter only
    clear_events();
    tap("#", 45, 30);
    check_events("hash", "#");
    chk("hash_keeps_key_in", 32'(key_in), 32'h5);

    // bouncing '7'
    clear_events();
    for (int b = 0; b < 5; b++) begin
      pressed[key_idx("7")] = 1'b1;
      step(3);
      pressed = '0;
      step(3);
    end
    check_events("bounce", "");
    tap("7", 45, 30);
    check_events("bounce7", "7");

    // sequence 4,2,7,9,#
    clear_events();
    for (int i = 0; i < 5; i++) tap(seq[i], 45, 30);
    check_events("seq", "4279#");
    chk("seq_key_in", 32'(key_in), 32'h9);

    // long hold of '3'
    clear_events();
    pressed[key_idx("3")] = 1'b1;
    wait_kd(1'b1, "hold3_timeout");
    step(130);
    pressed = '0;
    step(40);
`ifdef KEYPAD_AUTOREPEAT_EN
    check_events("hold3", "3333");
`else
    check_events("hold3", "3");
`endif

    // reset while held, key still down afterwards
    pressed[key_idx("8")] = 1'b1;
    wait_kd(1'b1, "hold8_timeout");
    reset = 1'b1;
    #1;
    chk_reset_vals("mid_reset");
    step(1);
    chk_reset_vals("mid_reset_next");
    reset = 1'b0;
    clear_events();
    step(40);
    chk("redetect_kd", 32'(key_down), 32'h1);
    pressed = '0;
    step(30);
    check_events("redetect", "8");
    chk("redetect_key_in", 32'(key_in), 32'h8);

    // randomized presses, chords, bounce and resets against the model
    for (int t = 0; t < 30; t++) begin
      saved = '0;
      for (int k = 0; k < int'($urandom_range(1, 2)); k++) saved[$urandom_range(0, 15)] = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) begin
          pressed = saved;
          step($urandom_range(1, 4));
          pressed = '0;
          step($urandom_range(1, 4));
        end
      end
      pressed = saved;
      step($urandom_range(0, 50));
      pressed = '0;
      step($urandom_range(0, 35));
      if ($urandom_range(0, 9) == 0) begin
        reset = 1'b1;
        step(1);
        reset = 1'b0;
      end
    end
    pressed = '0;
    step(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
